song_sequencer: RTL and testbench

//   Autoplay engine for the piano: steps through a melody stored in an external synchronous ROM.

---
 rtl/song_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_song_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// song_sequencer: autoplay engine that steps through a melody held in an external
// synchronous ROM. Each ROM word is {freq_type, duration_ticks}. It drives the current
// key code and the percent-complete value, and accepts play/pause/resume/stop pulses.
module song_sequencer #(
    parameter int TICK_CYCLES = 1_000_000,
    parameter int TICK_W      = 20
) (
    input  logic        iClk,
    input  logic        iReset_n,
    input  logic        iPlay,
    input  logic        iPause,
    input  logic        iStop,
    input  logic [7:0]  iSongLen,
    output logic [7:0]  oRomAddr,
    input  logic [15:0] iRomData,
    output logic [7:0]  oFreqType,
    output logic [7:0]  oProgress,
    output logic        oPlaying,
    output logic        oDone
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY,
        PAUSE,
        PROG_ADD,
        PROG_SUB,
        DONE
    } seqState_t;

    seqState_t         state;
    seqState_t         stateNext;
    logic [7:0]        idx;
    logic [7:0]        lenQ;
    logic [7:0]        freqQ;
    logic [7:0]        durCnt;
    logic [7:0]        progress;
    logic [8:0]        rem;
    logic [TICK_W-1:0] tickCnt;
    logic              pausePend;
    logic              doneQ;

    logic startCmd;
    logic resumeCmd;
    logic tickWrap;
    logic noteEnd;
    logic pauseReq;
    logic subtractStep;
    logic lastNote;

    // Pause outranks play, so a simultaneous play+pause never starts or resumes.
    assign startCmd     = iPlay && !iPause && (iSongLen != 8'd0);
    assign resumeCmd    = iPlay && !iPause;
    assign tickWrap     = (tickCnt == TICK_W'(TICK_CYCLES - 1));
    assign noteEnd      = tickWrap && (durCnt == 8'd1);
    // A pause seen outside PLAY is remembered and taken in the next PLAY cycle.
    assign pauseReq     = iPause || pausePend;
    // Progress accumulator: rem holds 100*notes_done mod len, so each whole len
    // subtracted from it is one more percent.
    assign subtractStep = (rem >= {1'b0, lenQ});
    assign lastNote     = (idx == lenQ - 8'd1);

    // State register.
    always_ff @(posedge iClk or negedge iReset_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
        if (!iReset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode; stop wins from every state.
    always_comb begin
        // NOTE: default assignment first so no path leaves stateNext unassigned (no latch).
        stateNext = state;
        if (iStop) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE:     if (startCmd) stateNext = FETCH;
                FETCH:    stateNext = LOAD;
                LOAD:     stateNext = PLAY;
                PLAY: begin
                    if (noteEnd) begin
                        stateNext = PROG_ADD;
                    end else if (pauseReq) begin
                        stateNext = PAUSE;
                    end
                end
                PAUSE:    if (resumeCmd) stateNext = PLAY;
                PROG_ADD: stateNext = PROG_SUB;
                PROG_SUB: begin
                    if (!subtractStep) begin
                        stateNext = lastNote ? DONE : FETCH;
                    end
                end
                DONE:     if (startCmd) stateNext = FETCH;
                default:  stateNext = IDLE;
            endcase
        end
    end

    // Datapath: note index, tick/duration counters, progress accumulator, pending pause.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            idx       <= '0;
            lenQ      <= '0;
            freqQ     <= '0;
            durCnt    <= '0;
            progress  <= '0;
            rem       <= '0;
            tickCnt   <= '0;
            pausePend <= 1'b0;
            doneQ     <= 1'b0;
        end else begin
            doneQ <= (stateNext == DONE) && (state != DONE);
            if (iStop) begin
                idx       <= '0;
                freqQ     <= '0;
                progress  <= '0;
                rem       <= '0;
                pausePend <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (startCmd) begin
                            idx       <= '0;
                            lenQ      <= iSongLen;
                            freqQ     <= '0;
                            progress  <= '0;
                            rem       <= '0;
                            pausePend <= 1'b0;
                        end
                    end
                    FETCH: begin
                        if (iPause) pausePend <= 1'b1;
                    end
                    LOAD: begin
                        freqQ   <= iRomData[15:8];
                        durCnt  <= (iRomData[7:0] == 8'd0) ? 8'd1 : iRomData[7:0];
                        tickCnt <= '0;
                        if (iPause) pausePend <= 1'b1;
                    end
                    PLAY: begin
                        // The cycle just spent in PLAY always counts, even if we pause now.
                        if (tickWrap) begin
                            tickCnt <= '0;
                            durCnt  <= durCnt - 8'd1;
                        end else begin
                            tickCnt <= tickCnt + TICK_W'(1);
                        end
                        if (noteEnd) begin
                            pausePend <= pausePend || iPause;
                        end else if (pauseReq) begin
                            pausePend <= 1'b0;
                        end
                    end
                    PROG_ADD: begin
                        rem <= rem + 9'd100;
                        if (iPause) pausePend <= 1'b1;
                    end
                    PROG_SUB: begin
                        if (iPause) pausePend <= 1'b1;
                        if (subtractStep) begin
                            rem      <= rem - {1'b0, lenQ};
                            progress <= progress + 8'd1;
                        end else if (!lastNote) begin
                            idx <= idx + 8'd1;
                        end
                    end
                    default: begin
                        // PAUSE: counters and saved key code hold.
                    end
                endcase
            end
        end
    end

    // Output decode: the key code is audible only while the engine is running.
    always_comb begin
        oPlaying  = 1'b0;
        oFreqType = 8'd0;
        case (state)
            FETCH, LOAD, PLAY, PROG_ADD, PROG_SUB: begin
                oPlaying  = 1'b1;
                oFreqType = freqQ;
            end
            default: begin
                oPlaying  = 1'b0;
                oFreqType = 8'd0;
            end
        endcase
    end

    assign oRomAddr  = idx;
    assign oProgress = progress;
    assign oDone     = doneQ;

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: scoreboard bench. A reference model builds the expected
// cycle-by-cycle output trace of each song from the note list and the command
// schedule, compressed into runs of identical outputs; a monitor compresses the
// DUT outputs the same way and compares run by run.
module tb_song_sequencer;

    localparam int         TICK   = 10;
    localparam logic [2:0] C_NONE  = 3'b000;
    localparam logic [2:0] C_PLAY  = 3'b001;
    localparam logic [2:0] C_PAUSE = 3'b010;
    localparam logic [2:0] C_STOP  = 3'b100;

    typedef struct packed {
        logic [7:0] freq;
        logic [7:0] prog;
        logic [7:0] addr;
        logic       playing;
        logic       done;
    } obs_t;

    typedef struct {
        obs_t val;
        int   len;
    } run_t;

    logic        iClk;
    logic        iReset_n;
    logic        iPlay;
    logic        iPause;
    logic        iStop;
    logic [7:0]  iSongLen;
    logic [7:0]  oRomAddr;
    logic [15:0] iRomData;
    logic [7:0]  oFreqType;
    logic [7:0]  oProgress;
    logic        oPlaying;
    logic        oDone;

    logic [15:0] rom [256];

    int   checks = 0;
    int   errors = 0;
    obs_t expC[$];
    logic [2:0] cmds[$];
    run_t sbQ[$];
    bit   monActive = 1'b0;
    obs_t curVal;
    int   curLen = 0;
    int   runIdx = 0;

    song_sequencer #(.TICK_CYCLES(TICK), .TICK_W(4)) dut (
        .iClk      (iClk),
        .iReset_n  (iReset_n),
        .iPlay     (iPlay),
        .iPause    (iPause),
        .iStop     (iStop),
        .iSongLen  (iSongLen),
        .oRomAddr  (oRomAddr),
        .iRomData  (iRomData),
        .oFreqType (oFreqType),
        .oProgress (oProgress),
        .oPlaying  (oPlaying),
        .oDone     (oDone)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Synchronous ROM: data valid one cycle after the address.
    always @(posedge iClk) iRomData <= rom[oRomAddr];

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic close_run();
        run_t e;
        runIdx++;
        if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL run %0d: unexpected output run 0x%0h x%0d, expected nothing", runIdx, curVal, curLen);
        end else begin
            e = sbQ.pop_front();
            check($sformatf("run %0d value {freq,prog,addr,playing,done}", runIdx), 32'(curVal), 32'(e.val));
            check($sformatf("run %0d length", runIdx), curLen, e.len);
        end
    endtask

    // Monitor: compress DUT outputs into runs and compare each closed run.
    always @(negedge iClk) begin
        obs_t s;
        s.freq    = oFreqType;
        s.prog    = oProgress;
        s.addr    = oRomAddr;
        s.playing = oPlaying;
        s.done    = oDone;
        if (monActive) begin
            if (curLen == 0) begin
                curVal = s;
                curLen = 1;
            end else if (s == curVal) begin
                curLen++;
            end else begin
                close_run();
                curVal = s;
                curLen = 1;
            end
        end else if (curLen != 0) begin
            close_run();
            curLen = 0;
        end
    end

    task automatic step(input logic [2:0] cmd, input int f, input int p, input int a,
                        input bit pl, input bit dn);
        obs_t o;
        o.freq    = 8'(f);
        o.prog    = 8'(p);
        o.addr    = 8'(a);
        o.playing = pl;
        o.done    = dn;
        cmds.push_back(cmd);
        expC.push_back(o);
    endtask

    // Reference model: expected outputs after each clock edge for one song, given
    // an optional pause (note pNote, after pAt audible cycles, for pWait cycles)
    // and an optional stop command (note sNote, at audible cycle sAt).
    task automatic gen_song(input int len, input int pNote, input int pAt, input int pWait,
                            input int sNote, input int sAt, input logic [2:0] sCmd);
        int prog;
        int target;
        int pc;
        int f;
        int d;
        expC.delete();
        cmds.delete();
        step(C_PLAY, 0, 0, 0, 1'b1, 1'b0);   // fetch of note 0
        step(C_NONE, 0, 0, 0, 1'b1, 1'b0);   // load of note 0
        prog = 0;
        for (int k = 0; k < len; k++) begin
            f  = int'(rom[k][15:8]);
            d  = int'(rom[k][7:0]);
            if (d == 0) d = 1;
            pc = d * TICK;
            for (int p = 0; p < pc; p++) begin
                if (k == sNote && p == sAt) begin
                    step(sCmd, 0, 0, 0, 1'b0, 1'b0);
                    repeat (3) step(C_NONE, 0, 0, 0, 1'b0, 1'b0);
                    return;
                end
                if (k == pNote && p == pAt) begin
                    step(C_PAUSE, 0, prog, k, 1'b0, 1'b0);
                    repeat (pWait - 1) step(C_NONE, 0, prog, k, 1'b0, 1'b0);
                    step(C_PLAY, f, prog, k, 1'b1, 1'b0);
                end else begin
                    step(C_NONE, f, prog, k, 1'b1, 1'b0);
                end
            end
            // Between notes: one accumulate cycle, one cycle per percent gained, one decide cycle.
            step(C_NONE, f, prog, k, 1'b1, 1'b0);
            target = (100 * (k + 1)) / len;
            step(C_NONE, f, prog, k, 1'b1, 1'b0);
            while (prog < target) begin
                prog++;
                step(C_NONE, f, prog, k, 1'b1, 1'b0);
            end
            if (k == len - 1) begin
                step(C_NONE, 0, 100, k, 1'b0, 1'b1);
                repeat (3) step(C_NONE, 0, 100, k, 1'b0, 1'b0);
            end else begin
                repeat (2) step(C_NONE, f, prog, k + 1, 1'b1, 1'b0);
            end
        end
    endtask

    // Push the expected trace as runs, then drive the command schedule.
    task automatic run_scenario();
        run_t r;
        for (int i = 0; i < expC.size(); i++) begin
            if (i == 0 || expC[i] != r.val) begin
                if (i != 0) sbQ.push_back(r);
                r.val = expC[i];
                r.len = 1;
            end else begin
                r.len++;
            end
        end
        if (expC.size() != 0) sbQ.push_back(r);

        @(negedge iClk);
        for (int c = 0; c < cmds.size(); c++) begin
            iPlay  = cmds[c][0];
            iPause = cmds[c][1];
            iStop  = cmds[c][2];
            if (c == 1) iSongLen = 8'($urandom);   // must be ignored after start
            @(posedge iClk);
            #1;
            iPlay     = 1'b0;
            iPause    = 1'b0;
            iStop     = 1'b0;
            monActive = 1'b1;
            @(negedge iClk);
        end
        @(posedge iClk);
        #1;
        monActive = 1'b0;
        @(negedge iClk);
        #1;
    endtask

    task automatic random_rom(input int len, input int maxDur);
        for (int i = 0; i < len; i++) begin
            rom[i] = {8'($urandom_range(0, 255)), 8'($urandom_range(0, maxDur))};
        end
    endtask

    function automatic int note_cycles(input int k);
        int d;
        d = int'(rom[k][7:0]);
        if (d == 0) d = 1;
        return d * TICK;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, " oFreqType"}, 32'(oFreqType), 32'd0);
        check({tag, " oProgress"}, 32'(oProgress), 32'd0);
        check({tag, " oPlaying"},  32'(oPlaying),  32'd0);
        check({tag, " oDone"},     32'(oDone),     32'd0);
        check({tag, " oRomAddr"},  32'(oRomAddr),  32'd0);
    endtask

    initial begin
        int len;
        int pNote, pAt, pWait, sNote, sAt;
        logic [2:0] sCmd;

        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        iReset_n = 1'b0;
        iPlay    = 1'b0;
        iPause   = 1'b0;
        iStop    = 1'b0;
        iSongLen = 8'd0;

        // Reset state, then after release.
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        check_all_zero("reset");
        iReset_n = 1'b1;
        repeat (3) @(negedge iClk);
        check_all_zero("after reset");

        // Four-note melody with a zero duration on the last note.
        rom[0] = 16'h0802;
        rom[1] = 16'h0901;
        rom[2] = 16'h0A03;
        rom[3] = 16'h0B00;
        iSongLen = 8'd4;
        gen_song(4, -1, 0, 0, -1, 0, C_NONE);
        run_scenario();

        // Restart from DONE with three notes, then a single note.
        random_rom(3, 3);
        iSongLen = 8'd3;
        gen_song(3, -1, 0, 0, -1, 0, C_NONE);
        run_scenario();
        random_rom(1, 3);
        iSongLen = 8'd1;
        gen_song(1, -1, 0, 0, -1, 0, C_NONE);
        run_scenario();

        // Pause five cycles into a two-tick note, hold 50 cycles, resume.
        random_rom(2, 2);
        rom[0][7:0] = 8'd2;
        rom[0][15:8] = 8'h21;
        iSongLen = 8'd2;
        gen_song(2, 0, 5, 50, -1, 0, C_NONE);
        run_scenario();

        // Stop in the middle of the second note.
        random_rom(3, 3);
        rom[1][7:0] = 8'd2;
        iSongLen = 8'd3;
        gen_song(3, -1, 0, 0, 1, 7, C_STOP);
        run_scenario();

        // Stop, pause and play in the same cycle.
        random_rom(2, 3);
        iSongLen = 8'd2;
        gen_song(2, -1, 0, 0, 0, 4, C_STOP | C_PAUSE | C_PLAY);
        run_scenario();

        // Play with a zero song length stays idle.
        iSongLen = 8'd0;
        expC.delete();
        cmds.delete();
        step(C_PLAY, 0, 0, 0, 1'b0, 1'b0);
        repeat (5) step(C_NONE, 0, 0, 0, 1'b0, 1'b0);
        run_scenario();

        // Longest song.
        random_rom(255, 2);
        iSongLen = 8'd255;
        gen_song(255, -1, 0, 0, -1, 0, C_NONE);
        run_scenario();

        // Random songs with random pause and stop points.
        for (int it = 0; it < 10; it++) begin
            len = $urandom_range(1, 12);
            random_rom(len, 4);
            pNote = -1; pAt = 0; pWait = 0;
            sNote = -1; sAt = 0; sCmd = C_STOP;
            if ($urandom_range(0, 1) == 1) begin
                pNote = $urandom_range(0, len - 1);
                pAt   = $urandom_range(1, note_cycles(pNote) - 1);
                pWait = $urandom_range(1, 20);
            end
            if ($urandom_range(0, 3) == 0) begin
                sNote = $urandom_range(0, len - 1);
                sAt   = $urandom_range(0, note_cycles(sNote) - 1);
                sCmd  = C_STOP | 3'($urandom_range(0, 3));
            end
            iSongLen = 8'(len);
            gen_song(len, pNote, pAt, pWait, sNote, sAt, sCmd);
            run_scenario();
        end

        check("scoreboard drained", sbQ.size(), 0);

        // Reset asserted while the progress update is running.
        rom[0] = 16'h0C01;
        rom[1] = 16'h0D01;
        iSongLen = 8'd2;
        @(negedge iClk);
        iPlay = 1'b1;
        @(posedge iClk);
        #1;
        iPlay = 1'b0;
        repeat (13) @(posedge iClk);
        @(negedge iClk);
        check("pre-reset oPlaying", 32'(oPlaying), 32'd1);
        check("pre-reset oFreqType", 32'(oFreqType), 32'h0C);
        iReset_n = 1'b0;
        #1;
        check_all_zero("async reset");
        @(negedge iClk);
        iReset_n = 1'b1;
        repeat (30) @(negedge iClk);
        check_all_zero("idle after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
